// File: rtl/dma_axi_burst_engine.sv
// AXI burst mover: one INCR read burst is buffered in a FIFO and replayed as one INCR write burst.
// Optional DMA_ERR_CHECK_EN adds the sticky err flag; undefined, err is tied low.
module dma_axi_burst_engine #(
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read_signal,
    input  logic [31:0]         addr_read,
    input  logic [31:0]         addr_write,
    output logic                busy,
    output logic                err,
    output logic [31:0]         ARADDR,
    output logic [3:0]          ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY,
    output logic [31:0]         AWADDR,
    output logic [3:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wstate_t;

    rstate_t           r_rstate;
    wstate_t           r_wstate;
    logic              r_read_q;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [BW-1:0]     r_wbeat;
    logic              w_edge;
    logic              w_launch;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;

    // Every channel transfers on a cycle where VALID and READY are both high at the clock
    // edge; a source holds VALID and its payload stable until that handshake happens.
    assign w_edge   = read_signal & ~r_read_q;
    assign busy     = (r_rstate != R_IDLE) | (r_wstate != W_IDLE);
    assign w_launch = w_edge & ~busy;
    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign RREADY   = (r_rstate == R_DATA) & ~w_full;
    assign WVALID   = (r_wstate == W_DATA) & ~w_empty;
    assign WLAST    = WVALID & (r_wbeat == LAST_BEAT);
    assign WDATA    = r_mem[r_rptr];
    assign w_push   = RVALID & RREADY;
    assign w_pop    = WVALID & WREADY;

    assign ARLEN   = 4'(BURST_LEN - 1);
    assign AWLEN   = 4'(BURST_LEN - 1);
    assign ARSIZE  = 3'b010;
    assign AWSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign AWBURST = 2'b01;
    assign WSTRB   = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_read_q <= 1'b0;
        else     r_read_q <= read_signal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            ARVALID  <= 1'b0;
            ARADDR   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: if (w_launch) begin
                    ARADDR   <= addr_read;
                    ARVALID  <= 1'b1;
                    r_rstate <= R_AR;
                end
                R_AR: if (ARREADY) begin
                    ARVALID  <= 1'b0;
                    r_rstate <= R_DATA;
                end
                R_DATA: if (w_push && RLAST) r_rstate <= R_IDLE;
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // The AW phase may finish long before read data lands; W_DATA then just waits on the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            AWVALID  <= 1'b0;
            AWADDR   <= '0;
            BREADY   <= 1'b0;
            r_wbeat  <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: if (w_launch) begin
                    AWADDR   <= addr_write;
                    AWVALID  <= 1'b1;
                    r_wstate <= W_AW;
                end
                W_AW: if (AWREADY) begin
                    AWVALID  <= 1'b0;
                    r_wstate <= W_DATA;
                end
                W_DATA: if (w_pop) begin
                    if (WLAST) begin
                        BREADY   <= 1'b1;
                        r_wstate <= W_RESP;
                    end else begin
                        r_wbeat <= r_wbeat + 1'b1;
                    end
                end
                W_RESP: if (BVALID) begin
                    BREADY   <= 1'b0;
                    r_wbeat  <= '0;
                    r_wstate <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= RDATA;
    end

`ifdef DMA_ERR_CHECK_EN
    logic [BW-1:0] r_rbeat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rbeat <= '0;
            err     <= 1'b0;
        end else begin
            if (w_push) begin
                r_rbeat <= RLAST ? '0 : r_rbeat + 1'b1;
                if ((RRESP != 2'b00) || (RLAST && (r_rbeat != LAST_BEAT))) err <= 1'b1;
            end
            if (BVALID && BREADY && (BRESP != 2'b00)) err <= 1'b1;
            if (w_edge && busy) err <= 1'b1;
        end
    end
`else
    logic w_unused;

    assign err      = 1'b0;
    assign w_unused = ^{RRESP, BRESP};
`endif

endmodule

// File: tb/tb_dma_axi_burst_engine.sv
// Directed bench for dma_axi_burst_engine: a behavioural AXI slave on the falling edge,
// logged transfers compared against hand-computed burst contents.
module tb_dma_axi_burst_engine;
    localparam int BL = 16;
    localparam int DW = 32;
`ifdef DMA_ERR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          read_signal;
    logic [31:0]   addr_read, addr_write;
    logic          busy, err;
    logic [31:0]   ARADDR, AWADDR;
    logic [3:0]    ARLEN, AWLEN;
    logic [2:0]    ARSIZE, AWSIZE;
    logic [1:0]    ARBURST, AWBURST;
    logic          ARVALID, ARREADY, AWVALID, AWREADY;
    logic [DW-1:0] RDATA, WDATA;
    logic [1:0]    RRESP, BRESP;
    logic          RLAST, RVALID, RREADY;
    logic [3:0]    WSTRB;
    logic          WLAST, WVALID, WREADY, BVALID, BREADY;

    always #5 clk = ~clk;

    dma_axi_burst_engine dut (
        .clk(clk), .rst(rst), .read_signal(read_signal),
        .addr_read(addr_read), .addr_write(addr_write), .busy(busy), .err(err),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    // Knobs written only by the main sequence.
    int          ar_wait = 0;
    bit          r_toggle = 1'b0;
    logic [1:0]  bresp_knob = 2'b00;
    int          wr_low_until = 0;
    logic [31:0] r_base = '0;

    // Slave state and transfer logs written only by the slave process.
    int          cyc = 0;
    int          ar_ctr = 0, ar_hold_n = 0, ar_unstable = 0;
    logic [31:0] ar_first = '0, r_base_cur = '0;
    bit          r_active = 1'b0, r_hold = 1'b0, r_phase = 1'b0, b_pending = 1'b0;
    int          r_beat = 0, r_n = 0, b_n = 0;
    logic [31:0] ar_log[$];
    logic [31:0] aw_log[$];
    logic [DW-1:0] w_log[$];
    bit          wl_log[$];

    logic [DW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Slave: decide inputs for the next rising edge, then log the handshakes they produce.
    always @(negedge clk) begin
        if (rst) begin
            ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RDATA = '0; RRESP = 2'b00;
            AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
            r_active = 1'b0; r_hold = 1'b0; r_phase = 1'b0; b_pending = 1'b0; ar_ctr = 0;
        end else begin
            cyc++;
            BVALID = b_pending;
            BRESP  = bresp_knob;
            if (BVALID && BREADY) begin
                b_pending = 1'b0;
                b_n++;
            end
            WREADY = (cyc >= wr_low_until);
            if (WVALID && WREADY) begin
                w_log.push_back(WDATA);
                wl_log.push_back(WLAST);
                if (WLAST) b_pending = 1'b1;
            end
            if (!r_active) RVALID = 1'b0;
            else if (r_hold) RVALID = 1'b1;
            else if (r_toggle) begin
                r_phase = ~r_phase;
                RVALID  = r_phase;
            end else RVALID = 1'b1;
            RDATA = r_base_cur + r_beat;
            RLAST = RVALID && (r_beat == BL - 1);
            RRESP = 2'b00;
            if (RVALID && RREADY) begin
                r_n++;
                r_beat++;
                r_hold = 1'b0;
                if (RLAST) r_active = 1'b0;
            end else r_hold = RVALID;
            if (ARVALID) begin
                if (ar_ctr == 0) ar_first = ARADDR;
                else if (ARADDR !== ar_first) ar_unstable++;
                ARREADY = (ar_ctr >= ar_wait);
                if (ARREADY) begin
                    ar_log.push_back(ARADDR);
                    r_active = 1'b1; r_beat = 0; r_hold = 1'b0; r_phase = 1'b0;
                    r_base_cur = r_base;
                    ar_ctr = 0;
                end else begin
                    ar_ctr++;
                    ar_hold_n++;
                end
            end else begin
                ARREADY = 1'b0;
                ar_ctr  = 0;
            end
            AWREADY = AWVALID;
            if (AWVALID) aw_log.push_back(AWADDR);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        read_signal = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic launch(input logic [31:0] ra, input logic [31:0] wa);
        @(negedge clk);
        #2 read_signal = 1'b0;
        @(negedge clk);
        #2 addr_read = ra;
        addr_write = wa;
        read_signal = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        @(posedge clk);
        @(negedge clk);
        #1 chk({tag, "_busy"}, busy, 1'b1);
        while (busy && n < budget) begin
            @(negedge clk);
            #1 n++;
        end
        chk({tag, "_done"}, busy, 1'b0);
    endtask

    task automatic check_burst(input string tag, input logic [31:0] ra, input logic [31:0] wa,
                               input logic [31:0] base, input int ar0, input int aw0,
                               input int w0, input int b0);
        logic [DW-1:0] e;
        chk({tag, "_ar_n"}, ar_log.size() - ar0, 1);
        if (ar_log.size() > ar0) chk({tag, "_araddr"}, ar_log[ar0], ra);
        chk({tag, "_aw_n"}, aw_log.size() - aw0, 1);
        if (aw_log.size() > aw0) chk({tag, "_awaddr"}, aw_log[aw0], wa);
        chk({tag, "_w_n"}, w_log.size() - w0, BL);
        for (int i = 0; i < BL; i++) exp_q.push_back(base + i);
        for (int i = 0; i < BL; i++) begin
            e = exp_q.pop_front();
            if (w0 + i < w_log.size()) begin
                chk({tag, "_wdata"}, w_log[w0 + i], e);
                chk({tag, "_wlast"}, wl_log[w0 + i], (i == BL - 1));
            end
        end
        chk({tag, "_b_n"}, b_n - b0, 1);
        chk({tag, "_bready_busy"}, {BREADY, busy}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ar0, aw0, w0, b0, r0, h0, u0, n;
        rst = 1'b1;
        read_signal = 1'b0;
        addr_read = '0;
        addr_write = '0;
        repeat (3) @(negedge clk);
        #1 chk("rst_outs", {busy, err, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 7'd0);
        chk("const_ar", {ARLEN, ARSIZE, ARBURST}, {4'hF, 3'b010, 2'b01});
        chk("const_aw", {AWLEN, AWSIZE, AWBURST, WSTRB}, {4'hF, 3'b010, 2'b01, 4'hF});
        #1 rst = 1'b0;

        // T1: single zero-wait burst
        ar0 = ar_log.size(); aw0 = aw_log.size(); w0 = w_log.size(); b0 = b_n;
        r_base = 32'h0;
        launch(32'h0001_0000, 32'h0002_0000);
        wait_idle("t1", 200);
        check_burst("t1", 32'h0001_0000, 32'h0002_0000, 32'h0, ar0, aw0, w0, b0);
        chk("t1_err", err, 1'b0);

        // T2: read_signal held high must not relaunch; then a second pulse at +0x40
        ar0 = ar_log.size();
        repeat (4) @(negedge clk);
        #1 chk("t2_norelaunch", ar_log.size() - ar0, 0);
        chk("t2_idle", busy, 1'b0);
        ar0 = ar_log.size(); aw0 = aw_log.size(); w0 = w_log.size(); b0 = b_n;
        r_base = 32'h100;
        launch(32'h0001_0040, 32'h0002_0040);
        repeat (3) @(negedge clk);
        #2 read_signal = 1'b0;
        @(negedge clk);
        #2 read_signal = 1'b1;
        wait_idle("t2", 200);
        check_burst("t2", 32'h0001_0040, 32'h0002_0040, 32'h100, ar0, aw0, w0, b0);
        chk("t2_busy_edge_err", err, EXP_ERR);
        do_reset();
        #1 chk("t2_err_cleared", err, 1'b0);

        // T4: ARREADY delayed 5 cycles, RVALID every other cycle
        ar_wait = 5; r_toggle = 1'b1; r_base = 32'h200;
        ar0 = ar_log.size(); aw0 = aw_log.size(); w0 = w_log.size(); b0 = b_n;
        h0 = ar_hold_n; u0 = ar_unstable;
        launch(32'h0001_0080, 32'h0002_0080);
        wait_idle("t4", 400);
        check_burst("t4", 32'h0001_0080, 32'h0002_0080, 32'h200, ar0, aw0, w0, b0);
        chk("t4_ar_wait", ar_hold_n - h0, 5);
        chk("t4_ar_stable", ar_unstable - u0, 0);
        ar_wait = 0; r_toggle = 1'b0;

        // T3: WREADY low for 40 cycles; the FIFO must absorb the whole burst
        ar0 = ar_log.size(); aw0 = aw_log.size(); w0 = w_log.size(); b0 = b_n; r0 = r_n;
        r_base = 32'h300;
        wr_low_until = cyc + 40;
        launch(32'h0001_00C0, 32'h0002_00C0);
        n = 0;
        while (cyc < wr_low_until - 2 && n < 200) begin
            @(negedge clk);
            #1 n++;
        end
        chk("t3_r_full", r_n - r0, BL);
        chk("t3_w_stalled", w_log.size() - w0, 0);
        chk("t3_rready", RREADY, 1'b0);
        chk("t3_wvalid", WVALID, 1'b1);
        wait_idle("t3", 200);
        check_burst("t3", 32'h0001_00C0, 32'h0002_00C0, 32'h300, ar0, aw0, w0, b0);

        // T5: reset after 7 read beats, then a clean burst
        r0 = r_n; r_base = 32'h400;
        launch(32'h0001_0100, 32'h0002_0100);
        n = 0;
        while (r_n - r0 < 7 && n < 100) begin
            @(negedge clk);
            #1 n++;
        end
        chk("t5_r7", r_n - r0, 7);
        #1 rst = 1'b1;
        read_signal = 1'b0;
        #1 chk("t5_rst_outs", {ARVALID, AWVALID, WVALID, RREADY, BREADY, busy}, 6'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("t5_fifo_empty", {WVALID, busy, err}, 3'd0);
        ar0 = ar_log.size(); aw0 = aw_log.size(); w0 = w_log.size(); b0 = b_n;
        r_base = 32'h500;
        launch(32'h0001_0140, 32'h0002_0140);
        wait_idle("t5", 200);
        check_burst("t5", 32'h0001_0140, 32'h0002_0140, 32'h500, ar0, aw0, w0, b0);

        // T6: error response on B, then a clean burst, then reset
        bresp_knob = 2'b10; r_base = 32'h600;
        ar0 = ar_log.size(); aw0 = aw_log.size(); w0 = w_log.size(); b0 = b_n;
        launch(32'h0001_0180, 32'h0002_0180);
        wait_idle("t6", 200);
        check_burst("t6", 32'h0001_0180, 32'h0002_0180, 32'h600, ar0, aw0, w0, b0);
        chk("t6_err", err, EXP_ERR);
        bresp_knob = 2'b00; r_base = 32'h700;
        ar0 = ar_log.size(); aw0 = aw_log.size(); w0 = w_log.size(); b0 = b_n;
        launch(32'h0001_01C0, 32'h0002_01C0);
        wait_idle("t6b", 200);
        check_burst("t6b", 32'h0001_01C0, 32'h0002_01C0, 32'h700, ar0, aw0, w0, b0);
        chk("t6_err_sticky", err, EXP_ERR);
        do_reset();
        #1 chk("t6_err_rst", err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
